// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and lane helpers for the MIPS data-memory port
package mips_mem_pkg;

  // readcontrol encodings (unlisted codes load a full word)
  localparam logic [2:0] RC_LW  = 3'b000;
  localparam logic [2:0] RC_LH  = 3'b001;
  localparam logic [2:0] RC_LHU = 3'b010;
  localparam logic [2:0] RC_LB  = 3'b011;
  localparam logic [2:0] RC_LBU = 3'b100;

  // writecontrol encodings
  localparam logic [1:0] WC_SW   = 2'b00;
  localparam logic [1:0] WC_SH   = 2'b01;
  localparam logic [1:0] WC_SB   = 2'b10;
  localparam logic [1:0] WC_NONE = 2'b11;

  // MMIO register select, taken from addr[3:2]
  localparam logic [1:0] MMIO_CYC   = 2'd0;
  localparam logic [1:0] MMIO_ST    = 2'd1;
  localparam logic [1:0] MMIO_FAULT = 2'd2;
  localparam logic [1:0] MMIO_GPIO  = 2'd3;

  // fault register bit positions
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } acc_size_e;

  function automatic acc_size_e rd_size(input logic [2:0] rc);
    case (rc)
      RC_LH, RC_LHU: rd_size = SZ_HALF;
      RC_LB, RC_LBU: rd_size = SZ_BYTE;
      default:       rd_size = SZ_WORD;
    endcase
  endfunction

  function automatic acc_size_e wr_size(input logic [1:0] wc);
    case (wc)
      WC_SH:   wr_size = SZ_HALF;
      WC_SB:   wr_size = SZ_BYTE;
      default: wr_size = SZ_WORD;
    endcase
  endfunction

  // Force the low address bits onto the natural boundary of the access size
  function automatic logic [1:0] align_lo(input acc_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: align_lo = 2'b00;
      SZ_HALF: align_lo = {lo[1], 1'b0};
      default: align_lo = lo;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: is_misaligned = (lo != 2'b00);
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, write replication, load lane extraction and misalignment flags
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]  readcontrol,
  input  logic [1:0]  writecontrol,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] writedata,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ld_misalign,
  output logic        st_misalign
);

  acc_size_e   rsz;
  acc_size_e   wsz;
  logic [1:0]  rlo;
  logic [1:0]  wlo;
  logic [31:0] shifted;

  // Lane selection always uses the naturally aligned offset; trapping is decided by the caller
  always_comb begin
    rsz         = rd_size(readcontrol);
    wsz         = wr_size(writecontrol);
    rlo         = align_lo(rsz, addr_lo);
    wlo         = align_lo(wsz, addr_lo);
    shifted     = rd_word >> {rlo, 3'b000};
    ld_misalign = is_misaligned(rsz, addr_lo);
    st_misalign = (writecontrol != WC_NONE) && is_misaligned(wsz, addr_lo);

    case (readcontrol)
      RC_LH:   rd_data = {{16{shifted[15]}}, shifted[15:0]};
      RC_LHU:  rd_data = {16'b0, shifted[15:0]};
      RC_LB:   rd_data = {{24{shifted[7]}}, shifted[7:0]};
      RC_LBU:  rd_data = {24'b0, shifted[7:0]};
      default: rd_data = rd_word;
    endcase

    case (writecontrol)
      WC_SW: begin
        byte_en = 4'b1111;
        wr_data = writedata;
      end
      WC_SH: begin
        byte_en = 4'b0011 << {wlo[1], 1'b0};
        wr_data = {2{writedata[15:0]}};
      end
      WC_SB: begin
        byte_en = 4'b0001 << wlo;
        wr_data = {4{writedata[7:0]}};
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = writedata;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// rtl/data_mem_port.sv - MIPS data-memory responder: word RAM plus MMIO window (optional MISALIGN_TRAP_EN)
module data_mem_port
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic [2:0]  readcontrol,
  input  logic [1:0]  writecontrol,
  output logic [31:0] readdata,
  output logic [1:0]  fault,
  output logic [7:0]  gpio_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] cyc_q, cyc_d;
  logic [31:0] st_q, st_d;
  logic [1:0]  fault_q, fault_d;
  logic [7:0]  gpio_q, gpio_d;

  logic          in_ram, in_mmio;
  logic [AW-1:0] widx;
  logic [31:0]   mmio_word, rd_word, rd_data, wr_data;
  logic [3:0]    byte_en;
  logic          ld_misalign, st_misalign, ld_trap, st_trap;
  logic          do_store, ram_we;
  logic [1:0]    fault_set, fault_clr;

  assign in_ram   = (addr >> (AW + 2)) == 32'd0;
  assign in_mmio  = addr[31:4] == MMIO_BASE[31:4];
  assign widx     = addr[AW+1:2];
  assign ld_trap  = TRAP_EN && ld_misalign;
  assign st_trap  = TRAP_EN && st_misalign;
  assign do_store = memwrite && (writecontrol != WC_NONE);
  assign ram_we   = do_store && in_ram && !st_trap;

  // MMIO read mux; counters show their registered (pre-increment) value
  always_comb begin
    case (addr[3:2])
      MMIO_CYC:   mmio_word = cyc_q;
      MMIO_ST:    mmio_word = st_q;
      MMIO_FAULT: mmio_word = {30'b0, fault_q};
      default:    mmio_word = {24'b0, gpio_q};
    endcase
  end

  assign rd_word = in_ram ? mem_q[widx] : mmio_word;

  mem_lane_align u_lane (
    .readcontrol  (readcontrol),
    .writecontrol (writecontrol),
    .addr_lo      (addr[1:0]),
    .writedata    (writedata),
    .rd_word      (rd_word),
    .byte_en      (byte_en),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .ld_misalign  (ld_misalign),
    .st_misalign  (st_misalign)
  );

  // Unmapped or trapped loads read as zero
  assign readdata = (!(in_ram || in_mmio) || ld_trap) ? 32'd0 : rd_data;

  // Next-state for counters, GPIO and the W1C fault register (set beats clear)
  always_comb begin
    cyc_d     = cyc_q + 32'd1;
    st_d      = st_q;
    gpio_d    = gpio_q;
    fault_set = 2'b00;
    fault_clr = 2'b00;
    // a load is only meaningful when the cycle is not a store
    if (ld_trap && !memwrite) fault_set[FAULT_MISALIGN] = 1'b1;
    if (do_store) begin
      if (st_trap) begin
        fault_set[FAULT_MISALIGN] = 1'b1;
      end else if (in_ram) begin
        st_d = st_q + 32'd1;
      end else if (in_mmio) begin
        if (writecontrol != WC_SW) begin
          fault_set[FAULT_MISALIGN] = 1'b1;
        end else begin
          case (addr[3:2])
            MMIO_FAULT: fault_clr = writedata[1:0];
            MMIO_GPIO:  gpio_d    = writedata[7:0];
            default:    ;
          endcase
        end
      end else begin
        fault_set[FAULT_RANGE] = 1'b1;
      end
    end
    fault_d = (fault_q & ~fault_clr) | fault_set;
  end

  // MMIO register state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q   <= 32'd0;
      st_q    <= 32'd0;
      fault_q <= 2'b00;
      gpio_q  <= 8'd0;
    end else begin
      cyc_q   <= cyc_d;
      st_q    <= st_d;
      fault_q <= fault_d;
      gpio_q  <= gpio_d;
    end
  end

  // RAM byte-lane writes; contents survive reset but a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[widx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign fault    = fault_q;
  assign gpio_out = gpio_q;

endmodule

// File: tb/tb_data_mem_port.sv
// tb/tb_data_mem_port.sv - directed self-checking bench for data_mem_port
module tb_data_mem_port;
  import mips_mem_pkg::*;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [2:0]  readcontrol;
  logic [1:0]  writecontrol;
  logic [31:0] readdata;
  logic [1:0]  fault;
  logic [7:0]  gpio_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_port #(.DEPTH_WORDS(256), .MMIO_BASE(MB)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .addr         (addr),
    .writedata    (writedata),
    .readcontrol  (readcontrol),
    .writecontrol (writecontrol),
    .readdata     (readdata),
    .fault        (fault),
    .gpio_out     (gpio_out)
  );

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wc);
    @(negedge clk);
    memwrite = 1'b1; addr = a; writedata = wd; writecontrol = wc; readcontrol = RC_LW;
    @(negedge clk);
    memwrite = 1'b0; writecontrol = WC_NONE; addr = 32'd0; readcontrol = RC_LW;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] rc, output logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b0; writecontrol = WC_NONE; addr = a; readcontrol = rc;
    #1 d = readdata;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    addr = MB; #1;
    total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_cyc got=%h exp=%h", readdata, 32'd0); end
    addr = MB + 4; #1;
    total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_st got=%h exp=%h", readdata, 32'd0); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL reset_fault got=%b exp=%b", fault, 2'b00); end
    total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL reset_gpio got=%h exp=%h", gpio_out, 8'h00); end
    @(negedge clk);
    reset = 1'b0; addr = 32'd0;
  endtask

  task automatic test_word_byte();
    logic [31:0] d;
    store(32'h10, 32'h8765_4321, WC_SW);
    load(32'h10, RC_LW, d);
    total++; if (d !== 32'h8765_4321) begin bad++; $display("FAIL lw_10 got=%h exp=%h", d, 32'h8765_4321); end
    load(32'h13, RC_LB, d);
    total++; if (d !== 32'hFFFF_FF87) begin bad++; $display("FAIL lb_13 got=%h exp=%h", d, 32'hFFFF_FF87); end
    load(32'h13, RC_LBU, d);
    total++; if (d !== 32'h0000_0087) begin bad++; $display("FAIL lbu_13 got=%h exp=%h", d, 32'h0000_0087); end
    load(32'h10, RC_LB, d);
    total++; if (d !== 32'h0000_0021) begin bad++; $display("FAIL lb_10 got=%h exp=%h", d, 32'h0000_0021); end
  endtask

  task automatic test_half();
    logic [31:0] d;
    store(32'h20, 32'h0000_0000, WC_SW);
    store(32'h22, 32'h1234_BEEF, WC_SH);
    load(32'h20, RC_LW, d);
    total++; if (d !== 32'hBEEF_0000) begin bad++; $display("FAIL lw_20 got=%h exp=%h", d, 32'hBEEF_0000); end
    load(32'h22, RC_LH, d);
    total++; if (d !== 32'hFFFF_BEEF) begin bad++; $display("FAIL lh_22 got=%h exp=%h", d, 32'hFFFF_BEEF); end
    load(32'h22, RC_LHU, d);
    total++; if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_22 got=%h exp=%h", d, 32'h0000_BEEF); end
    load(32'h20, RC_LH, d);
    total++; if (d !== 32'h0000_0000) begin bad++; $display("FAIL lh_20 got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_sb_stcnt();
    logic [31:0] d;
    store(32'h40, 32'h1122_3344, WC_SW);
    store(32'h41, 32'hFFFF_FFAA, WC_SB);
    load(32'h40, RC_LW, d);
    total++; if (d !== 32'h1122_AA44) begin bad++; $display("FAIL sb_41 got=%h exp=%h", d, 32'h1122_AA44); end
    load(MB + 4, RC_LW, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL st_cnt_5 got=%0d exp=%0d", d, 5); end
  endtask

  task automatic test_range_mmio();
    logic [31:0] d;
    store(32'h0, 32'h1234_5678, WC_SW);
    store(32'h1000, 32'hDEAD_0000, WC_SW);
    load(32'h0, RC_LW, d);
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL oor_no_alias got=%h exp=%h", d, 32'h1234_5678); end
    total++; if (fault !== 2'b10) begin bad++; $display("FAIL oor_fault got=%b exp=%b", fault, 2'b10); end
    store(MB + 8, 32'd3, WC_SW);
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL w1c_clear got=%b exp=%b", fault, 2'b00); end
    store(MB + 4, 32'd99, WC_SW);
    load(MB + 4, RC_LW, d);
    total++; if (d !== 32'd6) begin bad++; $display("FAIL st_ro got=%0d exp=%0d", d, 6); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL ro_nofault got=%b exp=%b", fault, 2'b00); end
    store(32'h3FC, 32'hA5A5_5A5A, WC_SW);
    load(32'h3FC, RC_LW, d);
    total++; if (d !== 32'hA5A5_5A5A) begin bad++; $display("FAIL last_word got=%h exp=%h", d, 32'hA5A5_5A5A); end
    load(32'h400, RC_LW, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL oor_load got=%h exp=%h", d, 32'd0); end
    @(negedge clk);
    addr = 32'd0;
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL oor_load_nofault got=%b exp=%b", fault, 2'b00); end
  endtask

  task automatic test_misalign();
    logic [31:0] d;
    store(32'h12, 32'hDEAD_BEEF, WC_SW);
`ifdef MISALIGN_TRAP_EN
    load(32'h10, RC_LW, d);
    total++; if (d !== 32'h8765_4321) begin bad++; $display("FAIL trap_sw_nowrite got=%h exp=%h", d, 32'h8765_4321); end
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL trap_sw_fault got=%b exp=%b", fault, 2'b01); end
    store(MB + 8, 32'd1, WC_SW);
    load(32'h11, RC_LW, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL trap_lw_zero got=%h exp=%h", d, 32'd0); end
    @(negedge clk);
    addr = 32'd0;
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL trap_lw_fault got=%b exp=%b", fault, 2'b01); end
    store(MB + 8, 32'd1, WC_SW);
    load(MB + 4, RC_LW, d);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL trap_st_cnt got=%0d exp=%0d", d, 7); end
`else
    load(32'h10, RC_LW, d);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL align_sw got=%h exp=%h", d, 32'hDEAD_BEEF); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL align_sw_fault got=%b exp=%b", fault, 2'b00); end
    store(32'h23, 32'h0000_1357, WC_SH);
    load(32'h22, RC_LHU, d);
    total++; if (d !== 32'h0000_1357) begin bad++; $display("FAIL align_sh got=%h exp=%h", d, 32'h0000_1357); end
    load(32'h11, RC_LW, d);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL align_lw got=%h exp=%h", d, 32'hDEAD_BEEF); end
    load(MB + 4, RC_LW, d);
    total++; if (d !== 32'd9) begin bad++; $display("FAIL align_st_cnt got=%0d exp=%0d", d, 9); end
`endif
    store(MB + 12, 32'h0000_00C3, WC_SB);
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL mmio_sb_fault got=%b exp=%b", fault, 2'b01); end
    total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL mmio_sb_drop got=%h exp=%h", gpio_out, 8'h00); end
    store(MB + 8, 32'd1, WC_SW);
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL mmio_sb_clear got=%b exp=%b", fault, 2'b00); end
  endtask

  task automatic test_cycles_gpio();
    logic [31:0] c1, c2;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    load(MB, RC_LW, c1);
    total++; if (c1 !== 32'd1) begin bad++; $display("FAIL cyc_first got=%0d exp=%0d", c1, 1); end
    repeat (6) @(negedge clk);
    load(MB, RC_LW, c2);
    total++; if (c2 - c1 !== 32'd7) begin bad++; $display("FAIL cyc_diff got=%0d exp=%0d", c2 - c1, 7); end
    load(MB + 4, RC_LW, c1);
    total++; if (c1 !== 32'd0) begin bad++; $display("FAIL st_after_reset got=%0d exp=%0d", c1, 0); end
    store(MB + 12, 32'h0000_005A, WC_SW);
    total++; if (gpio_out !== 8'h5A) begin bad++; $display("FAIL gpio_write got=%h exp=%h", gpio_out, 8'h5A); end
    @(negedge clk);
    memwrite = 1'b1; addr = MB + 12; writedata = 32'h77; writecontrol = WC_SW;
    #2 reset = 1'b1;
    #1;
    total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL gpio_async_reset got=%h exp=%h", gpio_out, 8'h00); end
    @(negedge clk);
    total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL gpio_store_lost got=%h exp=%h", gpio_out, 8'h00); end
    memwrite = 1'b0; writecontrol = WC_NONE; addr = 32'd0;
    reset = 1'b0;
    @(negedge clk);
    total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL gpio_after_release got=%h exp=%h", gpio_out, 8'h00); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; addr = 32'd0; writedata = 32'd0;
    readcontrol = RC_LW; writecontrol = WC_NONE;
    test_reset();
    test_word_byte();
    test_half();
    test_sb_stcnt();
    test_range_mmio();
    test_misalign();
    test_cycles_gpio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
